// File: rtl/boot_pkg.sv
// boot_pkg: shared state encodings and constants for the UART boot loader
package boot_pkg;
  typedef enum logic [2:0] {WAIT_SYNC, LEN_H, LEN_L, DATA_H, DATA_L, CSUM, DONE} state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 receiver with input synchronizer, mid-bit sampling and glitch rejection
module uart_rx_byte
  import boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  rx_state_t r_state, w_next;
  logic [1:0] r_sync;
  logic r_prev, r_valid, w_valid, r_ferr, w_ferr, w_rx, w_tick, w_half;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [2:0] r_bit, w_bit;
  logic [7:0] r_shift, w_shift;
  assign w_rx = r_sync[1];
  assign w_tick = r_cnt == CW'(CLKS_PER_BIT - 1);
  assign w_half = r_cnt == CW'(CLKS_PER_BIT / 2 - 1);
  assign byte_out = r_shift;
  assign byte_valid = r_valid;
  assign frame_err = r_ferr;
  // synchronizer, edge history and receiver state registers; line resets to idle-high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
      r_prev <= 1'b1;
      r_state <= RX_IDLE;
      r_cnt <= '0;
      r_bit <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], rx};
      r_prev <= w_rx;
      r_state <= w_next;
      r_cnt <= w_cnt;
      r_bit <= w_bit;
      r_shift <= w_shift;
      r_valid <= w_valid;
      r_ferr <= w_ferr;
    end
  end
  // bit timing: confirm start at half a bit, then sample each bit centre, stop bit last
  always_comb begin
    w_next = r_state;
    w_cnt = r_cnt + 1'b1;
    w_bit = r_bit;
    w_shift = r_shift;
    w_valid = 1'b0;
    w_ferr = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_cnt = '0;
        if (r_prev && !w_rx) w_next = RX_START;
      end
      RX_START: if (w_half) begin
        w_cnt = '0;
        w_bit = '0;
        w_next = w_rx ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (w_tick) begin
        w_cnt = '0;
        w_shift = {w_rx, r_shift[7:1]};
        w_bit = r_bit + 1'b1;
        if (r_bit == 3'd7) w_next = RX_STOP;
      end
      RX_STOP: if (w_tick) begin
        w_cnt = '0;
        w_valid = w_rx;
        w_ferr = !w_rx;
        w_next = RX_IDLE;
      end
      default: w_next = RX_IDLE;
    endcase
  end
endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a checksummed program image over UART and writes it to instruction memory
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1250,
  parameter int IMEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [15:0] imem_w_addr,
  output logic [15:0] imem_din,
  output logic        imem_w_en,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);
  state_t r_state, w_next;
  logic [7:0] w_byte, r_hi, r_sum;
  logic w_valid, w_ferr, w_err, w_wr;
  logic r_wen, r_hold, r_done, r_err;
  logic [15:0] r_len, r_idx, r_addr, r_din;
  logic [16:0] w_len;
  assign w_len = {1'b0, r_len[15:8], w_byte};
  assign w_wr = w_valid && r_state == DATA_L;
  assign imem_w_addr = r_addr;
  assign imem_din = r_din;
  assign imem_w_en = r_wen;
  assign cpu_hold = r_hold;
  assign load_done = r_done;
  assign load_error = r_err;
  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .byte_out(w_byte),
    .byte_valid(w_valid),
    .frame_err(w_ferr)
  );
  // next-state and error detection; any error drops back to hunting for SYNC
  always_comb begin
    w_next = r_state;
    w_err = w_ferr && r_state != WAIT_SYNC && r_state != DONE;
    if (w_valid) begin
      case (r_state)
        WAIT_SYNC: w_next = w_byte == SYNC_BYTE ? LEN_H : WAIT_SYNC;
        LEN_H:     w_next = LEN_L;
        LEN_L: begin
          w_err = w_len > 17'(IMEM_WORDS);
          w_next = w_len == '0 ? CSUM : DATA_H;
        end
        DATA_H:    w_next = DATA_L;
        DATA_L:    w_next = r_idx + 16'd1 == r_len ? CSUM : DATA_H;
        CSUM: begin
          w_err = w_byte != r_sum;
          w_next = DONE;
        end
        default:   w_next = r_state;
      endcase
    end
    if (w_err) w_next = WAIT_SYNC;
  end
  // datapath: length, word index, high-byte latch, checksum, write port and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_SYNC;
      r_len <= '0;
      r_idx <= '0;
      r_hi <= '0;
      r_sum <= '0;
      r_addr <= '0;
      r_din <= '0;
      r_wen <= 1'b0;
      r_hold <= 1'b1;
      r_done <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wen <= w_wr;
      if (w_valid) r_sum <= r_state == WAIT_SYNC ? '0 : r_sum + w_byte;
      if (w_valid && r_state == LEN_H) r_len[15:8] <= w_byte;
      if (w_valid && r_state == LEN_L) begin
        r_len[7:0] <= w_byte;
        r_idx <= '0;
      end
      if (w_valid && r_state == DATA_H) r_hi <= w_byte;
      if (w_wr) begin
        r_addr <= r_idx;
        r_din <= {r_hi, w_byte};
        r_idx <= r_idx + 16'd1;
      end
      if (w_err) r_err <= 1'b1;
      else if (w_valid && r_state == WAIT_SYNC && w_byte == SYNC_BYTE) r_err <= 1'b0;
      if (r_state == CSUM && w_next == DONE) begin
        r_done <= 1'b1;
        r_hold <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: scoreboard bench driving UART frames and checking memory writes and status
module tb_uart_boot_loader;
  localparam int CPB = 4;
  localparam int WORDS = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic [15:0] imem_w_addr, imem_din;
  logic imem_w_en, cpu_hold, load_done, load_error;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [15:0] tx_words[$];
  logic prev_en = 1'b0;
  logic prev_done = 1'b0;

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .IMEM_WORDS(WORDS)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .imem_w_addr(imem_w_addr),
    .imem_din(imem_din),
    .imem_w_en(imem_w_en),
    .cpu_hold(cpu_hold),
    .load_done(load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // write monitor: every strobe is one cycle wide and must match the head of the scoreboard
  always @(negedge clk) begin
    if (imem_w_en) begin
      chk("wen_pulse", 32'(prev_en), 32'd0);
      chk("wr_avail", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("wr", {imem_w_addr, imem_din}, exp_q.pop_front());
    end
    if (load_done != prev_done) chk("hold_done", 32'({cpu_hold, load_done}), 32'({~load_done, load_done}));
    prev_en = imem_w_en;
    prev_done = load_done;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic settle();
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic send_image(input bit corrupt);
    logic [7:0] s;
    logic [15:0] n;
    n = 16'(tx_words.size());
    s = n[15:8] + n[7:0];
    send_byte(8'hA5);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    for (int i = 0; i < tx_words.size(); i++) begin
      exp_q.push_back({16'(i), tx_words[i]});
      send_byte(tx_words[i][15:8]);
      send_byte(tx_words[i][7:0]);
      s = s + tx_words[i][15:8] + tx_words[i][7:0];
    end
    send_byte(corrupt ? ~s : s);
    settle();
  endtask

  task automatic check_status(input string tag, input bit done, input bit err);
    chk({tag, "_done"}, 32'(load_done), 32'(done));
    chk({tag, "_hold"}, 32'(cpu_hold), 32'(!done));
    chk({tag, "_err"}, 32'(load_error), 32'(err));
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_addr"}, 32'(imem_w_addr), 32'd0);
    chk({tag, "_din"}, 32'(imem_din), 32'd0);
    chk({tag, "_wen"}, 32'(imem_w_en), 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
    chk({tag, "_done"}, 32'(load_done), 32'd0);
    chk({tag, "_err"}, 32'(load_error), 32'd0);
  endtask

  task automatic do_reset();
    rx = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tx_words = {16'h1234, 16'hABCD};
    send_image(1'b0);
    check_status("two_words", 1'b1, 1'b0);
    chk("addr_hold", {imem_w_addr, imem_din}, {16'd1, 16'hABCD});
    do_reset();
    tx_words = {};
    send_image(1'b0);
    check_status("empty", 1'b1, 1'b0);
    do_reset();
    tx_words = {16'h1122};
    send_image(1'b1);
    check_status("bad_csum", 1'b0, 1'b1);
    send_image(1'b0);
    check_status("retry", 1'b1, 1'b0);
    do_reset();
    tx_words = {16'h0102, 16'h0304, 16'hF0F1, 16'hFFFF};
    send_image(1'b0);
    check_status("max_len", 1'b1, 1'b0);
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h05);
    settle();
    check_status("too_long", 1'b0, 1'b1);
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h11, 1'b0);
    settle();
    check_status("stop_bit", 1'b0, 1'b1);
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    settle();
    exp_q.push_back({16'd0, 16'h1122});
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h34);
    settle();
    check_status("glitch", 1'b1, 1'b0);
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h11);
    rx = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("mid_rst");
    rst_n = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    check_idle("post_rst");
    tx_words = {16'hBEEF};
    send_image(1'b0);
    check_status("after_rst", 1'b1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
